// File: rtl/kbd_poll_if.sv
// kbd_poll_if: handshake bundle between the poll scheduler, the bit-level transceiver and the host.
interface kbd_poll_if;
  logic led_data_valid;
  logic [1:0] led_data_in;
  logic data_ready;
  logic is_mouse_data;
  logic [15:0] keyboard_data;
  logic link_up;
  logic tx_start;
  logic [4:0] tx_len;
  logic [20:0] tx_frame;
  logic tx_done;
  logic rx_enable;
  logic rx_valid;
  logic [20:0] rx_frame;
  logic rx_error;
  modport master (
    input led_data_valid, led_data_in, tx_done, rx_valid, rx_frame, rx_error,
    output data_ready, is_mouse_data, keyboard_data, link_up, tx_start, tx_len, tx_frame, rx_enable
  );
  modport slave (
    output led_data_valid, led_data_in, tx_done, rx_valid, rx_frame, rx_error,
    input data_ready, is_mouse_data, keyboard_data, link_up, tx_start, tx_len, tx_frame, rx_enable
  );
endinterface

// File: rtl/kbd_poll_scheduler.sv
// kbd_poll_scheduler: NeXT keyboard/mouse link sequencer - reset frame, KB/MS polling, LED frames, link supervision.
module kbd_poll_scheduler #(
  parameter int BIT_CYCLES = 265,
  parameter int RESET_GAP_BITS = 5,
  parameter int QUERY_GAP_BITS = 3,
  parameter int RESP_TIMEOUT_BITS = 32,
  parameter int MAX_FAILS = 4,
  parameter logic [7:0] KB_QUERY = 8'b00010000,
  parameter logic [7:0] MS_QUERY = 8'b00010001,
  parameter logic [18:0] LED_PREFIX = 19'h00E00
) (
  input logic clk,
  input logic rst,
  kbd_poll_if.master kbd
);
  localparam int RST_GAP = RESET_GAP_BITS * BIT_CYCLES;
  localparam int Q_GAP = QUERY_GAP_BITS * BIT_CYCLES;
  localparam int TMO = RESP_TIMEOUT_BITS * BIT_CYCLES;
  localparam int MAXC = TMO > RST_GAP ? (TMO > Q_GAP ? TMO : Q_GAP) : (RST_GAP > Q_GAP ? RST_GAP : Q_GAP);
  localparam int CW = $clog2(MAXC + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  typedef enum logic [2:0] {RST_SEND, RST_WAIT, GAP, SEND, WAIT_TX, WAIT_RX} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] fails_q;
  logic mouse_due_q, led_pend_q, led_slot_q;
  logic [1:0] led_q;
  logic data_ready_q, is_mouse_q, link_up_q, tx_start_q, rx_enable_q;
  logic [15:0] kbd_data_q;
  logic [4:0] tx_len_q;
  logic [20:0] tx_frame_q;
  logic rx_data, rx_ok, rx_done, fail_max, re_reset;
  always_comb begin
    rx_data = kbd.rx_valid && kbd.rx_frame[1:0] == 2'b10;
    rx_ok = rx_data || (kbd.rx_valid && kbd.rx_frame[1:0] == 2'b01);
    rx_done = kbd.rx_valid || kbd.rx_error || cnt_q == CW'(TMO - 1);
    fail_max = fails_q == FW'(MAX_FAILS - 1);
    re_reset = rx_done && !rx_ok && fail_max;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_SEND;
      cnt_q <= '0;
      fails_q <= '0;
      mouse_due_q <= 1'b0;
      led_pend_q <= 1'b0;
      led_slot_q <= 1'b0;
      led_q <= '0;
      data_ready_q <= 1'b0;
      is_mouse_q <= 1'b0;
      kbd_data_q <= '0;
      link_up_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_len_q <= '0;
      tx_frame_q <= '0;
      rx_enable_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      data_ready_q <= 1'b0;
      case (state_q)
        RST_SEND: begin
          tx_start_q <= 1'b1;
          tx_len_q <= 5'd21;
          tx_frame_q <= '0;
          led_slot_q <= 1'b0;
          state_q <= RST_WAIT;
        end
        RST_WAIT: if (kbd.tx_done) begin
          cnt_q <= CW'(RST_GAP - 1);
          state_q <= GAP;
        end
        GAP: if (cnt_q == '0) state_q <= SEND;
          else cnt_q <= cnt_q - 1'b1;
        SEND: begin
          // The pending bit is consumed here so a request arriving mid-frame still gets its own slot.
          tx_start_q <= 1'b1;
          led_slot_q <= led_pend_q;
          led_pend_q <= 1'b0;
          tx_len_q <= led_pend_q ? 5'd21 : 5'd8;
          tx_frame_q <= led_pend_q ? {LED_PREFIX, led_q} : {13'd0, mouse_due_q ? MS_QUERY : KB_QUERY};
          state_q <= WAIT_TX;
        end
        WAIT_TX: if (kbd.tx_done) begin
          cnt_q <= led_slot_q ? CW'(Q_GAP - 1) : '0;
          rx_enable_q <= !led_slot_q;
          state_q <= led_slot_q ? GAP : WAIT_RX;
        end
        WAIT_RX: if (!rx_done) cnt_q <= cnt_q + 1'b1;
          else begin
            rx_enable_q <= 1'b0;
            cnt_q <= CW'(Q_GAP - 1);
            mouse_due_q <= re_reset ? 1'b0 : !mouse_due_q;
            data_ready_q <= rx_data;
            kbd_data_q <= rx_data ? kbd.rx_frame[20:5] : kbd_data_q;
            is_mouse_q <= rx_data ? mouse_due_q : is_mouse_q;
            fails_q <= (rx_ok || fail_max) ? '0 : fails_q + 1'b1;
            link_up_q <= rx_ok ? 1'b1 : (fail_max ? 1'b0 : link_up_q);
            state_q <= re_reset ? RST_SEND : GAP;
          end
        default: state_q <= RST_SEND;
      endcase
      if (kbd.led_data_valid) begin
        led_q <= kbd.led_data_in;
        led_pend_q <= 1'b1;
      end
    end
  end
  assign kbd.data_ready = data_ready_q;
  assign kbd.is_mouse_data = is_mouse_q;
  assign kbd.keyboard_data = kbd_data_q;
  assign kbd.link_up = link_up_q;
  assign kbd.tx_start = tx_start_q;
  assign kbd.tx_len = tx_len_q;
  assign kbd.tx_frame = tx_frame_q;
  assign kbd.rx_enable = rx_enable_q;
endmodule

// File: tb/tb_kbd_poll_scheduler.sv
// tb_kbd_poll_scheduler: scenario tasks with a queue scoreboard for transmitted frames and delivered events.
module tb_kbd_poll_scheduler;
  localparam int BC = 265;
  localparam logic [7:0] KB = 8'b00010000;
  localparam logic [7:0] MS = 8'b00010001;
  localparam logic [20:0] IDLE = 21'b000000000110000000001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [25:0] exp_tx[$];
  logic [16:0] exp_rx[$];
  bit mouse_due = 1'b0;
  kbd_poll_if bus ();
  kbd_poll_scheduler dut (.clk(clk), .rst(rst), .kbd(bus));
  always #5 clk = ~clk;

  task automatic xfer(output logic [25:0] got, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_start && n < 20000);
    got = bus.tx_start ? {bus.tx_len, bus.tx_frame} : 'x;
    if (bus.tx_start) begin
      repeat (3) @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic respond(input logic [20:0] f, input bit err);
    repeat (2) @(negedge clk);
    bus.rx_frame = f;
    bus.rx_valid = !err;
    bus.rx_error = err;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic test_reset;
    logic [25:0] got, e;
    int n;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.tx_start, bus.tx_len, bus.tx_frame, bus.rx_enable, bus.link_up, bus.data_ready, bus.is_mouse_data, bus.keyboard_data} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0", {bus.tx_start, bus.tx_len, bus.tx_frame, bus.rx_enable, bus.link_up, bus.data_ready, bus.is_mouse_data, bus.keyboard_data});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.tx_start, bus.tx_len, bus.tx_frame} !== {1'b1, 5'd21, 21'd0}) begin
      errors++;
      $display("FAIL reset_frame: got %h expected %h", {bus.tx_start, bus.tx_len, bus.tx_frame}, {1'b1, 5'd21, 21'd0});
    end
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_pulse: got %b expected 0", bus.tx_start);
    end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    exp_tx.push_back({5'd8, 13'd0, KB});
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e || n <= 5 * BC || n > 5 * BC + 5) begin
      errors++;
      $display("FAIL reset_gap_kb_query: got %h after %0d clocks expected %h after more than %0d", got, n, e, 5 * BC);
    end
    respond(IDLE, 1'b0);
    checks++;
    if ({bus.data_ready, bus.rx_enable, bus.link_up} !== 3'b001) begin
      errors++;
      $display("FAIL first_link_up: got %b expected 001", {bus.data_ready, bus.rx_enable, bus.link_up});
    end
    mouse_due = 1'b1;
  endtask

  task automatic test_alternation;
    logic [25:0] got, e;
    int n;
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back({5'd8, 13'd0, mouse_due ? MS : KB});
      xfer(got, n);
      e = exp_tx.pop_front();
      checks++;
      if (got !== e || bus.rx_enable !== 1'b1) begin
        errors++;
        $display("FAIL alt_query%0d: got %h rx_enable %b expected %h rx_enable 1", i, got, bus.rx_enable, e);
      end
      respond(IDLE, 1'b0);
      checks++;
      if ({bus.data_ready, bus.rx_enable, bus.link_up} !== 3'b001) begin
        errors++;
        $display("FAIL alt_idle%0d: got %b expected 001", i, {bus.data_ready, bus.rx_enable, bus.link_up});
      end
      mouse_due = !mouse_due;
    end
  endtask

  task automatic test_data;
    logic [25:0] got, e;
    logic [16:0] d;
    logic [20:0] rep [2] = '{21'b011011001010000000010, {16'hBEEF, 5'b00010}};
    logic [16:0] exd [2] = '{{1'b0, 16'h6CA0}, {1'b1, 16'hBEEF}};
    int n;
    for (int i = 0; i < 2; i++) begin
      exp_tx.push_back({5'd8, 13'd0, mouse_due ? MS : KB});
      xfer(got, n);
      e = exp_tx.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL data_query%0d: got %h expected %h", i, got, e);
      end
      exp_rx.push_back(exd[i]);
      respond(rep[i], 1'b0);
      d = exp_rx.pop_front();
      checks++;
      if (bus.data_ready !== 1'b1 || {bus.is_mouse_data, bus.keyboard_data} !== d) begin
        errors++;
        $display("FAIL data_event%0d: got ready %b data %h expected ready 1 data %h", i, bus.data_ready, {bus.is_mouse_data, bus.keyboard_data}, d);
      end
      @(negedge clk);
      checks++;
      if (bus.data_ready !== 1'b0 || {bus.is_mouse_data, bus.keyboard_data} !== d) begin
        errors++;
        $display("FAIL data_hold%0d: got ready %b data %h expected ready 0 data %h", i, bus.data_ready, {bus.is_mouse_data, bus.keyboard_data}, d);
      end
      mouse_due = !mouse_due;
    end
  endtask

  task automatic test_led;
    logic [25:0] got, e;
    int n;
    for (int i = 0; i < 2; i++) begin
      exp_tx.push_back({5'd8, 13'd0, mouse_due ? MS : KB});
      xfer(got, n);
      e = exp_tx.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL led_pre_query%0d: got %h expected %h", i, got, e);
      end
      if (i == 1) begin
        bus.led_data_in = 2'b01;
        bus.led_data_valid = 1'b1;
        @(negedge clk);
        bus.led_data_in = 2'b11;
        @(negedge clk);
        bus.led_data_valid = 1'b0;
      end
      respond(IDLE, 1'b0);
      mouse_due = !mouse_due;
    end
    exp_tx.push_back({5'd21, 19'h00E00, 2'b11});
    exp_tx.push_back({5'd8, 13'd0, KB});
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e || bus.rx_enable !== 1'b0) begin
      errors++;
      $display("FAIL led_frame: got %h rx_enable %b expected %h rx_enable 0", got, bus.rx_enable, e);
    end
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL led_resume_kb: got %h expected %h", got, e);
    end
    respond(IDLE, 1'b0);
    mouse_due = 1'b1;
  endtask

  task automatic test_error_and_reset;
    logic [25:0] got, e;
    int n;
    logic [20:0] rep [3] = '{IDLE, 21'h000003, IDLE};
    bit err [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back({5'd8, 13'd0, mouse_due ? MS : KB});
      xfer(got, n);
      e = exp_tx.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL err_query%0d: got %h expected %h", i, got, e);
      end
      respond(rep[i], err[i]);
      checks++;
      if ({bus.data_ready, bus.rx_enable, bus.link_up} !== 3'b001) begin
        errors++;
        $display("FAIL err_outcome%0d: got %b expected 001", i, {bus.data_ready, bus.rx_enable, bus.link_up});
      end
      mouse_due = !mouse_due;
    end
    exp_tx.push_back({5'd8, 13'd0, KB});
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e || bus.rx_enable !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_query: got %h rx_enable %b expected %h rx_enable 1", got, bus.rx_enable, e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.rx_enable, bus.link_up, bus.tx_start} !== 3'b000) begin
      errors++;
      $display("FAIL midop_reset: got %b expected 000", {bus.rx_enable, bus.link_up, bus.tx_start});
    end
    exp_tx.push_back({5'd21, 21'd0});
    exp_tx.push_back({5'd8, 13'd0, KB});
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e || n != 1) begin
      errors++;
      $display("FAIL midop_reset_frame: got %h after %0d expected %h after 1", got, n, e);
    end
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL post_reset_kb: got %h expected %h", got, e);
    end
    respond(IDLE, 1'b0);
    mouse_due = 1'b1;
  endtask

  task automatic test_timeout;
    logic [25:0] got, e;
    int n, m;
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back({5'd8, 13'd0, mouse_due ? MS : KB});
      xfer(got, n);
      e = exp_tx.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL tmo_query%0d: got %h expected %h", i, got, e);
      end
      m = 0;
      do begin
        @(negedge clk);
        m++;
      end while (bus.rx_enable && m < 20000);
      checks++;
      if (m != 32 * BC || bus.link_up !== (i < 3)) begin
        errors++;
        $display("FAIL tmo_expiry%0d: got %0d clocks link_up %b expected %0d clocks link_up %b", i, m, bus.link_up, 32 * BC, i < 3);
      end
      mouse_due = !mouse_due;
    end
    exp_tx.push_back({5'd21, 21'd0});
    xfer(got, n);
    e = exp_tx.pop_front();
    checks++;
    if (got !== e || n != 1 || bus.link_up !== 1'b0) begin
      errors++;
      $display("FAIL rereset_frame: got %h after %0d link_up %b expected %h after 1 link_up 0", got, n, bus.link_up, e);
    end
  endtask

  initial begin
    bus.led_data_valid = 1'b0;
    bus.led_data_in = 2'b00;
    bus.tx_done = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    bus.rx_frame = '0;
    test_reset();
    test_alternation();
    test_data();
    test_led();
    test_error_and_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
